uart_ahb_arbiter: RTL and testbench

- Two-requester AHB-Lite arbiter and transfer sequencer in front of the AHB-to-APB UART bridge slave port.
- Requester 0 is the CPU load/store path; requester 1 is the debug/boot loader.
- Takes simple req/gnt/done requests, grants them round-robin, and drives one single-beat NONSEQ transfer at a time (address phase, then data phase) to the bridge.
- Returns read data, error status and a per-transfer timeout.

---
 rtl/uart_ahb_pkg.sv | 21 ++
 rtl/rr_arbiter2.sv | 15 +
 rtl/uart_ahb_arbiter.sv | 178 +++++++++++++++++
 tb/tb_uart_ahb_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ahb_pkg.sv
// Shared encodings and the FSM state type for the UART AHB arbiter.
package uart_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  // Width of the data-phase wait counter; covers the full TIMEOUT range.
  localparam int unsigned WAIT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to
// the pointer, and the pointer then moves to the loser.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic       valid_o,
  output logic       winner_o,
  output logic       next_ptr_o
);

  assign valid_o    = |req_i;
  assign winner_o   = (req_i == 2'b11) ? ptr_i : req_i[1];
  assign next_ptr_o = ~winner_o;

endmodule

// File: rtl/uart_ahb_arbiter.sv
// Two-requester AHB-Lite arbiter / single-beat transfer sequencer in front
// of the AHB-to-APB UART bridge slave port.
module uart_ahb_arbiter
  import uart_ahb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [1:0]             m_req_i,
  input  logic [1:0][ADDR_W-1:0] m_addr_i,
  input  logic [1:0]             m_write_i,
  input  logic [1:0][2:0]        m_size_i,
  input  logic [1:0][DATA_W-1:0] m_wdata_i,
  output logic [1:0]             m_gnt_o,
  output logic [1:0]             m_done_o,
  output logic [DATA_W-1:0]      m_rdata_o,
  output logic                   m_err_o,
  output logic                   m_timeout_o,
  output logic                   HSEL,
  output logic [ADDR_W-1:0]      HADDR,
  output logic [1:0]             HTRANS,
  output logic                   HWRITE,
  output logic [2:0]             HSIZE,
  output logic [2:0]             HBURST,
  output logic [DATA_W-1:0]      HWDATA,
  input  logic                   HREADYOUT_S,
  input  logic [1:0]             HRESP_S,
  input  logic [DATA_W-1:0]      HRDATA_S,
  output logic                   busy_o,
  output logic                   owner_o
);

  // Last wait count before the transfer is aborted.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [2:0]        size_q, size_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              timeout_q, timeout_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic arb_valid;
  logic arb_winner;
  logic arb_next_ptr;

  rr_arbiter2 u_rr (
    .req_i      (m_req_i),
    .ptr_i      (rr_ptr_q),
    .valid_o    (arb_valid),
    .winner_o   (arb_winner),
    .next_ptr_o (arb_next_ptr)
  );

  // Next-state and payload/result logic for the IDLE -> ADDR -> DATA sequence.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned and infers a latch.
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    addr_d    = addr_q;
    write_d   = write_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    gnt_d     = 2'b00;
    done_d    = 2'b00;
    rdata_d   = rdata_q;
    err_d     = err_q;
    timeout_d = timeout_q;
    wait_d    = wait_q;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          owner_d            = arb_winner;
          rr_ptr_d           = arb_next_ptr;
          addr_d             = m_addr_i[arb_winner];
          write_d            = m_write_i[arb_winner];
          size_d             = m_size_i[arb_winner];
          wdata_d            = m_wdata_i[arb_winner];
          gnt_d[arb_winner]  = 1'b1;
          state_d            = ADDR;
        end
      end
      ADDR: begin
        if (HREADYOUT_S) state_d = DATA;
      end
      DATA: begin
        if (HREADYOUT_S) begin
          // Completion; an ERROR seen with ready low is just another wait.
          done_d[owner_q] = 1'b1;
          timeout_d       = 1'b0;
          wait_d          = '0;
          state_d         = IDLE;
          if (HRESP_S != HRESP_OKAY) begin
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            err_d   = 1'b0;
            rdata_d = write_q ? '0 : HRDATA_S;
          end
        end else if (wait_q == WAIT_LAST) begin
          done_d[owner_q] = 1'b1;
          err_d           = 1'b1;
          timeout_d       = 1'b1;
          rdata_d         = '0;
          wait_d          = '0;
          state_d         = IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and payload registers; reset abandons any transfer without a done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rr_ptr_q  <= 1'b0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      size_q    <= '0;
      wdata_q   <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      wait_q    <= wait_d;
    end
  end

  assign HSEL        = (state_q == ADDR);
  assign HTRANS      = (state_q == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR       = addr_q;
  assign HWRITE      = write_q;
  assign HSIZE       = size_q;
  assign HBURST      = HBURST_SINGLE;
  assign HWDATA      = wdata_q;
  assign m_gnt_o     = gnt_q;
  assign m_done_o    = done_q;
  assign m_rdata_o   = rdata_q;
  assign m_err_o     = err_q;
  assign m_timeout_o = timeout_q;
  assign busy_o      = (state_q != IDLE);
  assign owner_o     = owner_q;

endmodule

// File: tb/tb_uart_ahb_arbiter.sv
// Directed bench for uart_ahb_arbiter: write, round-robin, waited read,
// ERROR response, timeout and mid-transfer reset.
module tb_uart_ahb_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                   clk_i = 1'b0;
  logic                   rst_ni = 1'b0;
  logic [1:0]             m_req_i = '0;
  logic [1:0][ADDR_W-1:0] m_addr_i = '0;
  logic [1:0]             m_write_i = '0;
  logic [1:0][2:0]        m_size_i = '0;
  logic [1:0][DATA_W-1:0] m_wdata_i = '0;
  logic [1:0]             m_gnt_o;
  logic [1:0]             m_done_o;
  logic [DATA_W-1:0]      m_rdata_o;
  logic                   m_err_o;
  logic                   m_timeout_o;
  logic                   HSEL;
  logic [ADDR_W-1:0]      HADDR;
  logic [1:0]             HTRANS;
  logic                   HWRITE;
  logic [2:0]             HSIZE;
  logic [2:0]             HBURST;
  logic [DATA_W-1:0]      HWDATA;
  logic                   HREADYOUT_S = 1'b1;
  logic [1:0]             HRESP_S = 2'b00;
  logic [DATA_W-1:0]      HRDATA_S = '0;
  logic                   busy_o;
  logic                   owner_o;

  int compared   = 0;
  int mismatched = 0;

  uart_ahb_arbiter #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(4)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .m_req_i     (m_req_i),
    .m_addr_i    (m_addr_i),
    .m_write_i   (m_write_i),
    .m_size_i    (m_size_i),
    .m_wdata_i   (m_wdata_i),
    .m_gnt_o     (m_gnt_o),
    .m_done_o    (m_done_o),
    .m_rdata_o   (m_rdata_o),
    .m_err_o     (m_err_o),
    .m_timeout_o (m_timeout_o),
    .HSEL        (HSEL),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HWRITE      (HWRITE),
    .HSIZE       (HSIZE),
    .HBURST      (HBURST),
    .HWDATA      (HWDATA),
    .HREADYOUT_S (HREADYOUT_S),
    .HRESP_S     (HRESP_S),
    .HRDATA_S    (HRDATA_S),
    .busy_o      (busy_o),
    .owner_o     (owner_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and settle just after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_htrans", 64'(HTRANS), 64'h0);
    check("rst_hsel",   64'(HSEL),   64'h0);
    check("rst_hburst", 64'(HBURST), 64'h0);
    check("rst_busy",   64'(busy_o), 64'h0);
    check("rst_gnt",    64'(m_gnt_o), 64'h0);
    tick();
    tick();
    rst_ni = 1'b1;
    tick();

    // Test 1: requester 0 writes 0x41 to 0x1000_0000, zero-wait slave
    m_req_i      = 2'b01;
    m_addr_i[0]  = 32'h1000_0000;
    m_write_i[0] = 1'b1;
    m_size_i[0]  = 3'd2;
    m_wdata_i[0] = 32'h0000_0041;
    tick();  // cycle 1
    m_req_i = 2'b00;
    check("t1_gnt_c1",    64'(m_gnt_o), 64'h1);
    check("t1_htrans_c1", 64'(HTRANS),  64'h2);
    check("t1_hwrite_c1", 64'(HWRITE),  64'h1);
    check("t1_hsel_c1",   64'(HSEL),    64'h1);
    check("t1_haddr_c1",  64'(HADDR),   64'h1000_0000);
    check("t1_hsize_c1",  64'(HSIZE),   64'h2);
    tick();  // cycle 2
    check("t1_gnt_c2",    64'(m_gnt_o), 64'h0);
    check("t1_hwdata_c2", 64'(HWDATA),  64'h41);
    check("t1_htrans_c2", 64'(HTRANS),  64'h0);
    check("t1_done_c2",   64'(m_done_o), 64'h0);
    tick();  // cycle 3
    check("t1_done_c3",   64'(m_done_o), 64'h1);
    check("t1_err_c3",    64'(m_err_o),  64'h0);
    check("t1_rdata_c3",  64'(m_rdata_o), 64'h0);
    check("t1_busy_c3",   64'(busy_o),   64'h0);
    tick();

    // Test 3: requester 1 reads with 3 wait cycles (pointer now favours 1)
    m_req_i      = 2'b10;
    m_addr_i[1]  = 32'h1000_0004;
    m_write_i[1] = 1'b0;
    m_size_i[1]  = 3'd2;
    tick();  // cycle 1
    m_req_i = 2'b00;
    check("t3_gnt_c1",    64'(m_gnt_o), 64'h2);
    check("t3_owner_c1",  64'(owner_o), 64'h1);
    check("t3_hwrite_c1", 64'(HWRITE),  64'h0);
    tick();  // cycle 2
    HREADYOUT_S = 1'b0;
    tick();  // cycle 3
    tick();  // cycle 4
    tick();  // cycle 5
    check("t3_done_c5", 64'(m_done_o), 64'h0);
    HREADYOUT_S = 1'b1;
    HRDATA_S    = 32'hDEAD_BEEF;
    tick();  // cycle 6
    check("t3_done_c6",  64'(m_done_o),  64'h2);
    check("t3_rdata_c6", 64'(m_rdata_o), 64'hDEAD_BEEF);
    check("t3_err_c6",   64'(m_err_o),   64'h0);
    tick();
    check("t3_rdata_hold", 64'(m_rdata_o), 64'hDEAD_BEEF);

    // Test 2: both requesters request back-to-back; expect 0, 1, 0
    m_req_i      = 2'b11;
    m_write_i    = 2'b00;
    m_addr_i[0]  = 32'h1000_0010;
    m_addr_i[1]  = 32'h1000_0020;
    HRDATA_S     = 32'h0000_0011;
    tick();  // cycle 1
    check("t2_gnt_a",   64'(m_gnt_o), 64'h1);
    check("t2_owner_a", 64'(owner_o), 64'h0);
    tick();  // cycle 2
    tick();  // cycle 3
    check("t2_done_a",  64'(m_done_o), 64'h1);
    tick();  // cycle 4
    check("t2_gnt_b",   64'(m_gnt_o), 64'h2);
    check("t2_owner_b", 64'(owner_o), 64'h1);
    check("t2_haddr_b", 64'(HADDR),   64'h1000_0020);
    tick();  // cycle 5
    tick();  // cycle 6
    check("t2_done_b",  64'(m_done_o), 64'h2);
    tick();  // cycle 7
    m_req_i = 2'b00;
    check("t2_gnt_c",   64'(m_gnt_o), 64'h1);
    check("t2_owner_c", 64'(owner_o), 64'h0);
    tick();  // cycle 8
    tick();  // cycle 9
    check("t2_done_c",  64'(m_done_o),  64'h1);
    check("t2_rdata_c", 64'(m_rdata_o), 64'h11);
    tick();

    // Test 4: two-cycle ERROR response on a read by requester 0
    m_req_i  = 2'b01;
    HRDATA_S = 32'h5555_AAAA;
    tick();  // cycle 1
    m_req_i = 2'b00;
    tick();  // cycle 2
    HREADYOUT_S = 1'b0;
    HRESP_S     = 2'b01;
    tick();  // cycle 3
    check("t4_done_c3", 64'(m_done_o), 64'h0);
    HREADYOUT_S = 1'b1;
    tick();  // cycle 4
    HRESP_S = 2'b00;
    check("t4_done_c4",    64'(m_done_o),    64'h1);
    check("t4_err_c4",     64'(m_err_o),     64'h1);
    check("t4_timeout_c4", 64'(m_timeout_o), 64'h0);
    check("t4_rdata_c4",   64'(m_rdata_o),   64'h0);
    tick();

    // Test 5: timeout with TIMEOUT = 4 on a write by requester 1
    m_req_i      = 2'b10;
    m_write_i[1] = 1'b1;
    m_wdata_i[1] = 32'h0000_00AB;
    tick();  // cycle 1
    m_req_i = 2'b00;
    tick();  // cycle 2
    HREADYOUT_S = 1'b0;
    check("t5_hwdata_c2", 64'(HWDATA), 64'hAB);
    tick();  // cycle 3
    tick();  // cycle 4
    tick();  // cycle 5
    check("t5_done_c5", 64'(m_done_o), 64'h0);
    tick();  // cycle 6
    HREADYOUT_S = 1'b1;
    check("t5_done_c6",    64'(m_done_o),    64'h2);
    check("t5_err_c6",     64'(m_err_o),     64'h1);
    check("t5_timeout_c6", 64'(m_timeout_o), 64'h1);
    check("t5_busy_c6",    64'(busy_o),      64'h0);
    tick();
    check("t5_timeout_hold", 64'(m_timeout_o), 64'h1);
    // Next request is served normally
    m_req_i      = 2'b01;
    m_write_i[0] = 1'b1;
    m_wdata_i[0] = 32'h0000_0042;
    tick();  // cycle 1
    m_req_i = 2'b00;
    check("t5n_gnt_c1", 64'(m_gnt_o), 64'h1);
    tick();  // cycle 2
    tick();  // cycle 3
    check("t5n_done_c3",    64'(m_done_o),    64'h1);
    check("t5n_err_c3",     64'(m_err_o),     64'h0);
    check("t5n_timeout_c3", 64'(m_timeout_o), 64'h0);
    tick();

    // Test 6: reset asserted during DATA
    m_req_i      = 2'b01;
    m_write_i[0] = 1'b1;
    m_addr_i[0]  = 32'h1000_0030;
    m_wdata_i[0] = 32'h0000_0077;
    tick();  // cycle 1
    m_req_i = 2'b00;
    tick();  // cycle 2 (DATA)
    HREADYOUT_S = 1'b0;
    check("t6_busy_pre", 64'(busy_o), 64'h1);
    rst_ni = 1'b0;
    #1;
    check("t6_busy_rst",   64'(busy_o),   64'h0);
    check("t6_haddr_rst",  64'(HADDR),    64'h0);
    check("t6_hwdata_rst", 64'(HWDATA),   64'h0);
    check("t6_hwrite_rst", 64'(HWRITE),   64'h0);
    check("t6_htrans_rst", 64'(HTRANS),   64'h0);
    check("t6_err_rst",    64'(m_err_o),  64'h0);
    HREADYOUT_S = 1'b1;
    tick();
    check("t6_done_r1", 64'(m_done_o), 64'h0);
    tick();
    check("t6_done_r2", 64'(m_done_o), 64'h0);
    rst_ni = 1'b1;
    tick();
    check("t6_done_r3", 64'(m_done_o), 64'h0);
    // Simultaneous request after reset: requester 0 has priority
    m_req_i = 2'b11;
    tick();
    m_req_i = 2'b00;
    check("t6_gnt_post",   64'(m_gnt_o), 64'h1);
    check("t6_owner_post", 64'(owner_o), 64'h0);
    tick();
    tick();
    check("t6_done_post", 64'(m_done_o), 64'h1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
